// File: rtl/ni_pkg.sv
// rtl/ni_pkg.sv - shared constants and flit-type helpers for the NI injection port
package ni_pkg;

  localparam int FLIT_W = 35;
  localparam int NUM_VC = 2;
  localparam int FT_HI  = 34;
  localparam int FT_LO  = 33;

  typedef enum logic [1:0] {
    FT_BODY     = 2'b00,
    FT_HEAD     = 2'b01,
    FT_TAIL     = 2'b10,
    FT_HEADTAIL = 2'b11
  } flit_type_e;

  function automatic flit_type_e flit_type(input logic [FLIT_W-1:0] f);
    return flit_type_e'(f[FT_HI:FT_LO]);
  endfunction

  // Any flit that opens a packet must obey a foreign VC lock.
  function automatic logic opens_packet(input logic [FLIT_W-1:0] f);
    return (flit_type(f) == FT_HEAD) || (flit_type(f) == FT_HEADTAIL);
  endfunction

endpackage

// File: rtl/ni_vc_fifo.sv
// rtl/ni_vc_fifo.sv - per-VC synchronous FIFO with extra-bit full/empty pointers
module ni_vc_fifo #(
  parameter int WIDTH = 35,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] front,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign front   = mem[rd_ptr[AW-1:0]];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset: emptiness is decided by the pointers alone.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/ni_inject_port.sv
// rtl/ni_inject_port.sv - two-VC injection stage with credit flow control and round-robin arbitration
module ni_inject_port #(
  parameter int FLIT_W     = ni_pkg::FLIT_W,
  parameter int FIFO_DEPTH = 4,
  parameter int CREDITS    = 4
) (
  input  logic              clk,
  input  logic              RST_,
  input  logic [FLIT_W-1:0] core_data,
  input  logic              core_valid,
  input  logic              core_vch,
  output logic [1:0]        core_rdy,
  output logic [FLIT_W-1:0] ODATA,
  output logic              OVALID,
  output logic              OVCH,
  input  logic [1:0]        IACK,
  input  logic [1:0]        IRDY,
  input  logic [1:0]        ILCK,
  output logic              err_credit
);
  import ni_pkg::*;

  localparam int CW = $clog2(CREDITS + 1);

  logic [FLIT_W-1:0] front [NUM_VC];
  logic [CW-1:0]     credit [NUM_VC];
  logic [1:0]        full;
  logic [1:0]        empty;
  logic [1:0]        push;
  logic [1:0]        pop;
  logic [1:0]        elig;
  logic [1:0]        pkt_open;
  logic              rr;
  logic              send;
  logic              gnt_vc;

  for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
    assign push[v] = core_valid && (core_vch == 1'(v)) && !full[v];
    assign pop[v]  = send && (gnt_vc == 1'(v));
    // A foreign lock only stalls a new packet, never our own open one.
    assign elig[v] = !empty[v] && (credit[v] != '0) && IRDY[v] &&
                     !(opens_packet(front[v]) && ILCK[v] && !pkt_open[v]);

    ni_vc_fifo #(
      .WIDTH (FLIT_W),
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk   (clk),
      .rst_n (RST_),
      .push  (push[v]),
      .pop   (pop[v]),
      .din   (core_data),
      .front (front[v]),
      .full  (full[v]),
      .empty (empty[v])
    );
  end

  assign core_rdy = ~full;

  always_comb begin
    send   = |elig;
    gnt_vc = (&elig) ? rr : !elig[0];
  end

  always_ff @(posedge clk or negedge RST_) begin
    if (!RST_) begin
      ODATA      <= '0;
      OVALID     <= 1'b0;
      OVCH       <= 1'b0;
      err_credit <= 1'b0;
      rr         <= 1'b0;
      pkt_open   <= 2'b00;
      for (int v = 0; v < NUM_VC; v++) credit[v] <= CW'(CREDITS);
    end else begin
      OVALID <= send;
      if (send) begin
        ODATA <= front[gnt_vc];
        OVCH  <= gnt_vc;
        case (flit_type(front[gnt_vc]))
          FT_HEAD: pkt_open[gnt_vc] <= 1'b1;
          FT_TAIL: pkt_open[gnt_vc] <= 1'b0;
          default: ;
        endcase
      end
      if (&elig) rr <= !gnt_vc;
      for (int v = 0; v < NUM_VC; v++) begin
        case ({IACK[v], pop[v]})
          2'b10: begin
            if (credit[v] == CW'(CREDITS)) err_credit <= 1'b1;
            else                           credit[v]  <= credit[v] + CW'(1);
          end
          2'b01:   credit[v] <= credit[v] - CW'(1);
          default: ;
        endcase
      end
    end
  end

endmodule
